// File: rtl/trig_seq_ctrl.sv
// Multi-channel trigger sequencer: a synchronised external edge or a software pulse
// starts an independent delay + pulse burst on every idle, enabled channel.
`timescale 1ns/1ps
module trig_seq_ctrl #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32,
    parameter int NUM_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   trigger_in,
    input  logic                   sw_trig,
    input  logic [1:0]             cfg_edge_mode,
    input  logic [N_CH-1:0]        cfg_ch_en,
    input  logic [N_CH*CNT_W-1:0]  cfg_delay,
    input  logic [N_CH*CNT_W-1:0]  cfg_cycle,
    input  logic [N_CH*CNT_W-1:0]  cfg_width,
    input  logic [N_CH*NUM_W-1:0]  cfg_pic_num,
    input  logic                   ovr_clr,
    output logic [N_CH-1:0]        trig_to_camera,
    output logic [N_CH-1:0]        trig_to_core,
    output logic [N_CH-1:0]        busy,
    output logic [N_CH-1:0]        overrun
);

    typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W:0]   WIDE_ONE = 1;
    localparam logic [NUM_W-1:0] NUM_ONE  = 1;

    logic sync1, sync2, sync_prev, hw_evt, hw_edge, evt;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
            hw_evt    <= 1'b0;
        end else begin
            sync1     <= trigger_in;
            sync2     <= sync1;
            sync_prev <= sync2;
            hw_evt    <= hw_edge;
        end
    end

    // NOTE: every combinational output is assigned before the case so no latch is inferred.
    always_comb begin
        hw_edge = 1'b0;
        case (cfg_edge_mode)
            2'b00:   hw_edge = sync2 & ~sync_prev;
            2'b01:   hw_edge = ~sync2 & sync_prev;
            2'b10:   hw_edge = sync2 ^ sync_prev;
            default: hw_edge = 1'b0;
        endcase
    end

    assign evt = hw_evt | sw_trig;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t           state, next_state;
        logic [CNT_W-1:0] cnt, cnt_next;
        logic [NUM_W-1:0] pulse, pulse_next;
        logic [CNT_W-1:0] d_last_sh, w_last_sh, l_last_sh;
        logic [NUM_W-1:0] p_last_sh;
        logic             cam_q, core_q, busy_q, ovr_q, load;

        logic [CNT_W-1:0] cfg_d, cfg_c, cfg_w, w_eff, c_eff, l_len;
        logic [CNT_W-1:0] d_last, w_last, l_last;
        logic [NUM_W-1:0] cfg_p, p_last;
        logic [CNT_W:0]   w_inc, c_wide;

        // Phase lengths are reduced to "last count" values so each phase compares cnt directly.
        always_comb begin
            cfg_d  = cfg_delay[i*CNT_W +: CNT_W];
            cfg_c  = cfg_cycle[i*CNT_W +: CNT_W];
            cfg_w  = cfg_width[i*CNT_W +: CNT_W];
            cfg_p  = cfg_pic_num[i*NUM_W +: NUM_W];
            w_eff  = (cfg_w == '0) ? CNT_ONE : cfg_w;
            w_inc  = {1'b0, w_eff} + WIDE_ONE;
            c_wide = ({1'b0, cfg_c} > w_inc) ? {1'b0, cfg_c} : w_inc;
            c_eff  = c_wide[CNT_W] ? '1 : c_wide[CNT_W-1:0];
            l_len  = c_eff - w_eff;
            l_last = (l_len == '0) ? '0 : l_len - CNT_ONE;
            w_last = w_eff - CNT_ONE;
            d_last = cfg_d - CNT_ONE;
            p_last = cfg_p - NUM_ONE;
        end

        always_comb begin
            next_state = state;
            cnt_next   = cnt;
            pulse_next = pulse;
            load       = 1'b0;
            case (state)
                IDLE: begin
                    if (evt && cfg_ch_en[i] && cfg_p != '0) begin
                        load       = 1'b1;
                        cnt_next   = '0;
                        pulse_next = '0;
                        next_state = (cfg_d != '0) ? DELAY : HIGH;
                    end
                end
                DELAY: begin
                    if (cnt == d_last_sh) begin
                        cnt_next   = '0;
                        next_state = HIGH;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (cnt == w_last_sh) begin
                        cnt_next = '0;
                        if (pulse == p_last_sh) begin
                            next_state = IDLE;
                        end else begin
                            pulse_next = pulse + NUM_ONE;
                            next_state = LOW;
                        end
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
                LOW: begin
                    if (cnt == l_last_sh) begin
                        cnt_next   = '0;
                        next_state = HIGH;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
                default: next_state = IDLE;
            endcase
            if (state != IDLE && !cfg_ch_en[i]) begin
                next_state = IDLE;
                cnt_next   = '0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= IDLE;
                cnt       <= '0;
                pulse     <= '0;
                d_last_sh <= '0;
                w_last_sh <= '0;
                l_last_sh <= '0;
                p_last_sh <= '0;
                cam_q     <= 1'b0;
                core_q    <= 1'b0;
                busy_q    <= 1'b0;
                ovr_q     <= 1'b0;
            end else begin
                state  <= next_state;
                cnt    <= cnt_next;
                pulse  <= pulse_next;
                cam_q  <= (next_state == HIGH);
                core_q <= (next_state == HIGH) && (state != HIGH);
                busy_q <= (next_state != IDLE);
                // A new overrun in the same cycle as the clear must survive.
                ovr_q  <= (evt && state != IDLE) | (ovr_q & ~ovr_clr);
                if (load) begin
                    d_last_sh <= d_last;
                    w_last_sh <= w_last;
                    l_last_sh <= l_last;
                    p_last_sh <= p_last;
                end
            end
        end

        assign trig_to_camera[i] = cam_q;
        assign trig_to_core[i]   = core_q;
        assign busy[i]           = busy_q;
        assign overrun[i]        = ovr_q;
    end

endmodule

// File: tb/tb_trig_seq_ctrl.sv
// Directed bench for trig_seq_ctrl: hand-computed pulse timing, overrun, abort and reset cases.
`timescale 1ns/1ps
module tb_trig_seq_ctrl;

    localparam int N_CH  = 4;
    localparam int CNT_W = 32;
    localparam int NUM_W = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  trigger_in;
    logic                  sw_trig;
    logic [1:0]            cfg_edge_mode;
    logic [N_CH-1:0]       cfg_ch_en;
    logic [N_CH*CNT_W-1:0] cfg_delay;
    logic [N_CH*CNT_W-1:0] cfg_cycle;
    logic [N_CH*CNT_W-1:0] cfg_width;
    logic [N_CH*NUM_W-1:0] cfg_pic_num;
    logic                  ovr_clr;
    logic [N_CH-1:0]       trig_to_camera;
    logic [N_CH-1:0]       trig_to_core;
    logic [N_CH-1:0]       busy;
    logic [N_CH-1:0]       overrun;

    trig_seq_ctrl #(.N_CH(N_CH), .CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .trigger_in     (trigger_in),
        .sw_trig        (sw_trig),
        .cfg_edge_mode  (cfg_edge_mode),
        .cfg_ch_en      (cfg_ch_en),
        .cfg_delay      (cfg_delay),
        .cfg_cycle      (cfg_cycle),
        .cfg_width      (cfg_width),
        .cfg_pic_num    (cfg_pic_num),
        .ovr_clr        (ovr_clr),
        .trig_to_camera (trig_to_camera),
        .trig_to_core   (trig_to_core),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int cam_hi [N_CH];
    int core_cnt [N_CH];
    int first_rise [N_CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < N_CH; c++) begin
            if (trig_to_camera[c] === 1'b1) begin
                cam_hi[c]++;
                if (first_rise[c] < 0) first_rise[c] = cyc;
            end
            if (trig_to_core[c] === 1'b1) core_cnt[c]++;
        end
    endtask

    task automatic goto_cyc(input int n);
        while (cyc < n) step();
    endtask

    task automatic clear_stats();
        for (int c = 0; c < N_CH; c++) begin
            cam_hi[c]     = 0;
            core_cnt[c]   = 0;
            first_rise[c] = -1;
        end
    endtask

    task automatic set_cfg(input int ch, input logic [31:0] d, input logic [31:0] c,
                           input logic [31:0] w, input logic [15:0] p);
        cfg_delay[ch*CNT_W +: CNT_W]   = d;
        cfg_cycle[ch*CNT_W +: CNT_W]   = c;
        cfg_width[ch*CNT_W +: CNT_W]   = w;
        cfg_pic_num[ch*NUM_W +: NUM_W] = p;
    endtask

    initial begin
        int k, m, n, e;
        logic [5:0] cam_pat;
        logic [5:0] busy_pat;
        int d_tab [N_CH];

        rst_n         = 1'b0;
        trigger_in    = 1'b0;
        sw_trig       = 1'b0;
        cfg_edge_mode = 2'b00;
        cfg_ch_en     = '0;
        cfg_delay     = '0;
        cfg_cycle     = '0;
        cfg_width     = '0;
        cfg_pic_num   = '0;
        ovr_clr       = 1'b0;
        clear_stats();

        // Reset state
        step(); step(); step();
        check("rst_cam", 32'(trig_to_camera), 0);
        check("rst_core", 32'(trig_to_core), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovr", 32'(overrun), 0);
        rst_n = 1'b1;
        step(); step();

        // Long burst on ch0, rising mode: D=300 C=3750 W=10 P=8
        set_cfg(0, 300, 3750, 10, 8);
        cfg_ch_en = 4'b0001;
        step();
        clear_stats();
        trigger_in = 1'b1;
        k = cyc + 1;
        goto_cyc(k + 302);
        check("b1_cam_pre", 32'(trig_to_camera[0]), 0);
        check("b1_busy_dly", 32'(busy[0]), 1);
        goto_cyc(k + 303);
        check("b1_cam_rise", 32'(trig_to_camera[0]), 1);
        check("b1_core_rise", 32'(trig_to_core[0]), 1);
        goto_cyc(k + 304);
        check("b1_core_once", 32'(trig_to_core[0]), 0);
        goto_cyc(k + 312);
        check("b1_cam_last_w", 32'(trig_to_camera[0]), 1);
        goto_cyc(k + 313);
        check("b1_cam_fall", 32'(trig_to_camera[0]), 0);
        goto_cyc(k + 303 + 3750);
        check("b1_core_p1", 32'(trig_to_core[0]), 1);
        goto_cyc(k + 26562);
        check("b1_cam_L", 32'(trig_to_camera[0]), 1);
        check("b1_busy_L", 32'(busy[0]), 1);
        goto_cyc(k + 26563);
        check("b1_busy_end", 32'(busy), 0);
        check("b1_cam_end", 32'(trig_to_camera[0]), 0);
        check("b1_cam_cycles", 32'(cam_hi[0]), 80);
        check("b1_core_count", 32'(core_cnt[0]), 8);
        check("b1_first_rise", 32'(first_rise[0]), 32'(k + 303));
        check("b1_no_ovr", 32'(overrun), 0);

        // Second rising edge mid-burst -> overrun, clear/set race, clear, abort
        trigger_in = 1'b0;
        step(); step(); step();
        trigger_in = 1'b1;
        k = cyc + 1;
        goto_cyc(k + 50);
        trigger_in = 1'b0;
        goto_cyc(k + 60);
        trigger_in = 1'b1;
        m = cyc;
        goto_cyc(m + 3);
        check("ov_before", 32'(overrun[0]), 0);
        goto_cyc(m + 4);
        check("ov_set", 32'(overrun[0]), 1);
        goto_cyc(k + 303);
        check("ov_burst_kept", 32'(trig_to_camera[0]), 1);
        check("ov_burst_core", 32'(trig_to_core[0]), 1);
        goto_cyc(k + 400);
        check("ov_sticky", 32'(overrun[0]), 1);
        ovr_clr = 1'b1;
        sw_trig = 1'b1;
        step();
        ovr_clr = 1'b0;
        sw_trig = 1'b0;
        check("ov_set_wins", 32'(overrun[0]), 1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        check("ov_cleared", 32'(overrun[0]), 0);
        cfg_ch_en = 4'b0000;
        step();
        check("ov_abort_busy", 32'(busy[0]), 0);

        // Both-edge mode, four channels with D = 0/5/10/20, C=4 W=1 P=2
        cfg_edge_mode = 2'b10;
        d_tab[0] = 0; d_tab[1] = 5; d_tab[2] = 10; d_tab[3] = 20;
        for (int c = 0; c < N_CH; c++) set_cfg(c, 32'(d_tab[c]), 4, 1, 2);
        cfg_ch_en = 4'b1111;
        step();
        clear_stats();
        trigger_in = 1'b0;
        e = cyc + 3;
        goto_cyc(e + 10);
        check("be_busy_e10", 32'(busy), 32'b1110);
        goto_cyc(e + 11);
        check("be_busy_e11", 32'(busy), 32'b1100);
        goto_cyc(e + 30);
        for (int c = 0; c < N_CH; c++) begin
            check($sformatf("be_first_rise_ch%0d", c), 32'(first_rise[c]), 32'(e + 1 + d_tab[c]));
            check($sformatf("be_strobes_ch%0d", c), 32'(core_cnt[c]), 2);
            check($sformatf("be_cam_cycles_ch%0d", c), 32'(cam_hi[c]), 2);
        end
        check("be_all_idle", 32'(busy), 0);

        // W=0 C=1 P=3 on ch2 -> W_eff=1, C_eff=2
        cfg_ch_en = 4'b0100;
        set_cfg(2, 0, 1, 0, 3);
        step();
        clear_stats();
        sw_trig = 1'b1;
        n = cyc;
        step();
        sw_trig = 1'b0;
        cam_pat  = 6'b010101;
        busy_pat = 6'b011111;
        for (int j = 0; j < 6; j++) begin
            goto_cyc(n + 1 + j);
            check($sformatf("w0_cam_%0d", j), 32'(trig_to_camera[2]), 32'(cam_pat[j]));
            check($sformatf("w0_busy_%0d", j), 32'(busy[2]), 32'(busy_pat[j]));
        end
        check("w0_strobes", 32'(core_cnt[2]), 3);

        // P=0 with sw_trig -> nothing, no flag
        set_cfg(2, 0, 1, 0, 0);
        step();
        clear_stats();
        sw_trig = 1'b1;
        step();
        sw_trig = 1'b0;
        step(); step(); step(); step();
        check("p0_busy", 32'(busy), 0);
        check("p0_cam", 32'(cam_hi[2]), 0);
        check("p0_ovr", 32'(overrun), 0);

        // Mode 11: hardware edges ignored, sw_trig still starts a burst
        cfg_edge_mode = 2'b11;
        cfg_ch_en = 4'b0001;
        set_cfg(0, 2, 4, 2, 1);
        step();
        clear_stats();
        for (int j = 0; j < 6; j++) begin
            trigger_in = ~trigger_in;
            step(); step(); step();
        end
        step(); step(); step(); step();
        check("m11_no_cam", 32'(cam_hi[0]), 0);
        check("m11_no_busy", 32'(busy), 0);
        sw_trig = 1'b1;
        n = cyc;
        step();
        sw_trig = 1'b0;
        goto_cyc(n + 2);
        check("m11_sw_cam_pre", 32'(trig_to_camera[0]), 0);
        check("m11_sw_busy", 32'(busy[0]), 1);
        goto_cyc(n + 3);
        check("m11_sw_cam", 32'(trig_to_camera[0]), 1);
        check("m11_sw_core", 32'(trig_to_core[0]), 1);
        goto_cyc(n + 5);
        check("m11_sw_done", 32'(busy[0]), 0);

        // Enable dropped during HIGH on ch1
        cfg_ch_en = 4'b0010;
        set_cfg(1, 0, 10, 5, 2);
        step();
        sw_trig = 1'b1;
        n = cyc;
        step();
        sw_trig = 1'b0;
        goto_cyc(n + 2);
        check("abort_cam_high", 32'(trig_to_camera[1]), 1);
        cfg_ch_en = 4'b0000;
        step();
        check("abort_cam", 32'(trig_to_camera[1]), 0);
        check("abort_busy", 32'(busy[1]), 0);
        clear_stats();
        goto_cyc(n + 20);
        check("abort_no_more_cam", 32'(cam_hi[1]), 0);
        check("abort_no_more_core", 32'(core_cnt[1]), 0);

        // Asynchronous reset mid-DELAY, then a fresh burst
        cfg_ch_en = 4'b0001;
        set_cfg(0, 50, 8, 3, 1);
        step();
        sw_trig = 1'b1;
        n = cyc;
        step();
        sw_trig = 1'b0;
        goto_cyc(n + 10);
        check("rstmid_busy_before", 32'(busy[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_cam", 32'(trig_to_camera), 0);
        step();
        rst_n = 1'b1;
        step();
        check("rstmid_stay_idle", 32'(busy), 0);
        sw_trig = 1'b1;
        n = cyc;
        step();
        sw_trig = 1'b0;
        goto_cyc(n + 50);
        check("rstmid_resume_pre", 32'(trig_to_camera[0]), 0);
        goto_cyc(n + 51);
        check("rstmid_resume_cam", 32'(trig_to_camera[0]), 1);
        check("rstmid_resume_core", 32'(trig_to_core[0]), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trig_seq_ctrl.md
# trig_seq_ctrl

Multi-channel successor to the single-channel camera trigger delay controller. Each qualifying edge on the shared external trigger (or a software trigger) starts an independent burst per enabled channel: programmable delay, then a programmable number of pulses with programmable width and period. It drives the camera trigger lines and the matching per-pulse strobes to the processing core, and reports busy and overrun status per channel to the register block.

## Interface
- N_CH, 4, number of independent trigger channels
- CNT_W, 32, width of delay/cycle/width counters
- NUM_W, 16, width of pulse-count field
- clk  in  1  system clock; only clock domain
- rst_n  in  1  asynchronous reset, active low
- trigger_in  in  1  external trigger, asynchronous to clk
- sw_trig  in  1  software trigger, one-cycle pulse, synchronous to clk
- cfg_edge_mode  in  2  00 rising, 01 falling, 10 both edges, 11 hardware trigger disabled
- cfg_ch_en  in  N_CH  per-channel enable
- cfg_delay  in  N_CH*CNT_W  per-channel delay D, channel i at [i*CNT_W +: CNT_W]
- cfg_cycle  in  N_CH*CNT_W  per-channel pulse period C
- cfg_width  in  N_CH*CNT_W  per-channel pulse width W
- cfg_pic_num  in  N_CH*NUM_W  per-channel pulse count P
- ovr_clr  in  1  clears all overrun flags
- trig_to_camera  out  N_CH  camera trigger, high W cycles per pulse
- trig_to_core  out  N_CH  one-cycle strobe in first high cycle of each pulse
- busy  out  N_CH  channel not IDLE
- overrun  out  N_CH  sticky: trigger arrived while channel busy

## Operation
- trigger_in passes through 2 synchronizer flops, then an edge-detect flop; edge qualified per cfg_edge_mode produces internal evt. evt = qualified hw edge OR sw_trig; sw_trig works in all modes including 11.
- Per channel FSM: IDLE, DELAY, HIGH, LOW. All outputs driven from flops.
- IDLE: on evt with cfg_ch_en[i]=1 and P!=0, latch D, C, W, P into shadow registers; go to DELAY if D>0, else HIGH. P=0: evt ignored, no flag.
- Effective values: W_eff = max(W,1); C_eff = max(C, W_eff+1).
- DELAY: D cycles, then HIGH.
- HIGH: W_eff cycles, trig_to_camera=1; then LOW if pulses remain, else IDLE (no trailing low phase).
- LOW: C_eff-W_eff cycles, then HIGH.
- Config changes mid-burst have no effect (shadowed); take effect on next accepted trigger.
- evt while channel not IDLE: ignored, overrun[i] set. Set and ovr_clr in same cycle: set wins.
- cfg_ch_en[i] deasserted in any non-IDLE state: abort; next cycle state IDLE, trig_to_camera[i]=0, busy[i]=0. No partial strobe.
- Channels fully independent; the same evt starts all idle enabled channels in the same cycle.
- Counters are CNT_W wide, count up from 0 and compare to shadow values; no wrap inside a phase for any legal value (C_eff computed at CNT_W+1 bits, saturates at 2^CNT_W-1).

## Timing
- Reset: all outputs 0, all FSMs IDLE, sync/edge flops 0, shadows 0. Reset mid-burst terminates outputs immediately (asynchronous).
- trigger_in transition sampled at clock edge k -> evt high in cycle k+2.
- Accepted evt in cycle E: busy high from E+1; pulse n (0..P-1) has trig_to_camera high cycles E+D+1+n*C_eff through E+D+n*C_eff+W_eff; trig_to_core high only in E+D+1+n*C_eff.
- Last high cycle L = E+D+(P-1)*C_eff+W_eff; busy low from L+1; evt at L+1 accepted, evt at or before L flags overrun.
- overrun set visible the cycle after the offending evt; cleared the cycle after ovr_clr.

## Test plan
- Ch0 D=300, C=3750, W=10, P=8, rising mode, trigger_in rises sampled at k -> 8 pulses of 10 cycles, first rise k+303, spacing 3750; busy drops at k+303+7*3750+10 - 1 + 1; no overrun.
- Same config, second rising edge mid-burst -> ignored, overrun[0]=1 until ovr_clr; ovr_clr asserted with concurrent new overrun -> stays 1.
- Both-edge mode, 4 channels with D=0/5/10/20, C=4, W=1, P=2 -> each channel first rise at evt+1+D, two strobes, independent busy.
- W=0, C=1, P=3 -> W_eff=1, C_eff=2, pulses alternating high/low; P=0 with sw_trig -> nothing, no flag.
- Mode 11, trigger_in toggling -> no output; sw_trig -> burst starts evt+1+D.
- cfg_ch_en[1] dropped during HIGH -> output 0 next cycle, busy 0; rst_n low mid-DELAY -> all outputs 0 immediately, resume on next trigger.
